// File: rtl/mem_arbiter.sv
// N-master arbiter (round-robin or fixed priority, bounded bus lock) in front of a single-port memory.
// Latency: grant is combinational in the request cycle; read data valid is registered, one cycle later.
// Backpressure: an ungranted master holds req/we/addr/wdata until it sees its grant bit.
module mem_arbiter #(
    parameter int NUM_MASTERS   = 3,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int PRIORITY_MODE = 0,
    parameter int LOCK_MAX      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_MASTERS-1:0]        i_req,
    input  logic [NUM_MASTERS-1:0]        i_we,
    input  logic [NUM_MASTERS-1:0]        i_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
    output logic [NUM_MASTERS-1:0]        o_gnt,
    output logic [NUM_MASTERS-1:0]        o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [ADDR_W-1:0]             o_mem_rd_addr,
    output logic                          o_mem_wr_en,
    output logic [ADDR_W-1:0]             o_mem_wr_addr,
    output logic [DATA_W-1:0]             o_mem_wr_data,
    input  logic [DATA_W-1:0]             i_mem_rd_data
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t              state_q, state_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     mask_vld_q, mask_vld_d;
    logic [PTR_W-1:0]         mask_idx_q, mask_idx_d;
    logic [NUM_MASTERS-1:0]   rvalid_q, rvalid_d;

    logic                     hold;
    logic                     gnt_any;
    logic [PTR_W-1:0]         gnt_idx;
    logic [NUM_MASTERS-1:0]   eligible;
    logic [CNT_W-1:0]         cnt_next;

    // Successor index with wrap at NUM_MASTERS (N need not be a power of two).
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
        if (int'(k) >= NUM_MASTERS - 1) begin
            return '0;
        end
        return k + PTR_W'(1);
    endfunction

    // Grant selection: lock owner keeps the bus while it still requests with lock;
    // otherwise arbitrate among requesters, skipping a master just force-released.
    always_comb begin : arb_comb
        int j;
        j        = 0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        eligible = i_req;
        if (mask_vld_q) begin
            eligible[mask_idx_q] = 1'b0;
        end
        hold = !i_rst && (state_q == ST_LOCKED) && i_req[owner_q] && i_lock[owner_q];

        if (i_rst) begin
            gnt_any = 1'b0;
        end else if (hold) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
        end else if (PRIORITY_MODE == 1) begin
            // Scan high to low so the lowest requesting index is the last to win.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                j = int'(rr_ptr_q) + i;
                if (j >= NUM_MASTERS) begin
                    j = j - NUM_MASTERS;
                end
                if (!gnt_any && eligible[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(j);
                end
            end
        end
    end

    // Memory port and grant vector driven from the winning master; all zero when idle.
    always_comb begin
        o_gnt         = '0;
        o_mem_rd_addr = '0;
        o_mem_wr_addr = '0;
        o_mem_wr_data = '0;
        o_mem_wr_en   = 1'b0;
        if (gnt_any) begin
            o_gnt[gnt_idx] = 1'b1;
            o_mem_rd_addr  = i_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            o_mem_wr_addr  = i_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            o_mem_wr_data  = i_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            o_mem_wr_en    = i_we[gnt_idx];
        end
    end

    // Lock FSM, round-robin pointer, release mask and read-valid next state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        mask_vld_d = 1'b0;
        mask_idx_d = mask_idx_q;
        cnt_next   = lock_cnt_q + CNT_W'(1);
        rvalid_d   = o_gnt & ~i_we;

        if (hold) begin
            if ((LOCK_MAX != 0) && (cnt_next == CNT_W'(LOCK_MAX))) begin
                // Burst limit reached: release and bench the owner for one cycle.
                state_d    = ST_UNLOCKED;
                lock_cnt_d = '0;
                mask_vld_d = 1'b1;
                mask_idx_d = owner_q;
                rr_ptr_d   = next_idx(owner_q);
            end else if (LOCK_MAX != 0) begin
                lock_cnt_d = cnt_next;
            end
        end else begin
            // Unlocked, or the owner dropped req/lock this cycle: normal arbitration.
            state_d    = ST_UNLOCKED;
            lock_cnt_d = '0;
            if (gnt_any) begin
                rr_ptr_d = next_idx(gnt_idx);
                if (i_lock[gnt_idx]) begin
                    if (LOCK_MAX == 1) begin
                        // A one-grant burst is exhausted by the acquiring grant itself.
                        mask_vld_d = 1'b1;
                        mask_idx_d = gnt_idx;
                    end else begin
                        state_d    = ST_LOCKED;
                        owner_d    = gnt_idx;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end
        end
    end

    // State registers; reset drops any lock and cancels a pending read valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_UNLOCKED;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rr_ptr_q   <= '0;
            mask_vld_q <= 1'b0;
            mask_idx_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_vld_q <= mask_vld_d;
            mask_idx_q <= mask_idx_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_rdata  = i_mem_rd_data;

endmodule
